dmi_jtag_dtm: RTL and testbench
===============================

# dmi_jtag_dtm

JTAG Debug Transport Module: the initiator end of the DMI link whose responder is the Debug Module. It oversamples an external JTAG port in the processor clock domain and runs the IEEE 1149.1 TAP controller. It also implements the RISC-V debug spec v1.00 DTM registers (IDCODE, DTMCS, DMI, BYPASS). DMI scans become single-cycle read/write strobes on the `DBG_IF` bus.

## Interface
- `ABITS`, 7: DMI address width; DMI scan register width is `ABITS+34`.
- `IDCODE`, 32'h1000_0001: value of the IDCODE register; bit 0 is forced to 1.
- `iClk` input 1: processor clock, rising edge; sole clock.
- `iRst_n` input 1: asynchronous, active-low reset.
- `iTck` input 1: JTAG TCK, asynchronous; sampled by `iClk`.
- `iTms` input 1: JTAG TMS, asynchronous.
- `iTdi` input 1: JTAG TDI, asynchronous.
- `oTdo` output 1: JTAG TDO.
- `oTdoEn` output 1: TDO drive enable; 1 only in Shift-DR/Shift-IR.
- `dmi` `DBG_IF.debugger`: drives `dm_access_valid`, `dm_read`, `dm_write`, `dm_addr[ABITS-1:0]`, `dm_wdata[31:0]`; samples `dm_rdata[31:0]`.

## Operation
- **Input synchronisation**
  - TCK, TMS and TDI each pass through a 2-FF synchroniser.
  - A third TCK flop gives `tck_rise` and `tck_fall` single-cycle pulses.
- **TAP FSM**
  - 16 states, advanced on `tck_rise` using synchronised TMS.
  - States: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
  - Transitions follow IEEE 1149.1 exactly; five TMS=1 edges reach TLR from any state.
- **Instruction register (5 bits)**
  - CapIR loads 5'b00001.
  - ShIR shifts LSB-first, with TDI into bit 4.
  - UpdIR latches the shifted value into the active IR.
  - TLR forces IR=0x01.
- **Register selection by IR**
  - 0x01 selects IDCODE; 0x10 selects DTMCS; 0x11 selects DMI.
  - All other codes select BYPASS, a 1-bit register that captures 0.
- **DTMCS read fields**
  - version=1 in [3:0].
  - abits=`ABITS` in [9:4].
  - dmistat=sticky status in [11:10].
  - idle=1 in [14:12].
  - All other bits read 0.
- **DTMCS write on UpdDR**
  - Bit 16 (dmireset) clears sticky status.
  - Bit 17 (dmihardreset) clears sticky status and cancels any pending request.
- **DMI scan register**
  - Layout: {addr[ABITS-1:0], data[31:0], op[1:0]}.
  - CapDR loads {last_addr, last_rdata, sticky}.
  - On UpdDR the op field selects the action, unless sticky is nonzero (then the update is ignored):
    - op=0: no-op.
    - op=1: read.
    - op=2: write.
    - op=3: sets sticky=2 (failed).
- **DMI request handshake**
  - The cycle after UpdDR, the block pulses `dm_access_valid` for exactly one `iClk`, with `dm_read` or `dm_write` high and addr/wdata held stable.
  - For reads, `dm_rdata` is captured into last_rdata in the same cycle. For writes, last_rdata is unchanged.
  - last_addr is updated on every issued request.
  - A CapDR on DMI while a request is pending sets sticky=3 (busy).
- **Shift data path**
  - The shift register shifts on `tck_rise` in Shift states, LSB out first.
  - `oTdo` takes the current LSB on `tck_fall`.

## Timing
- **Reset values**
  - All outputs 0.
  - TAP in TLR, IR=0x01, sticky=0, last_addr=0, last_rdata=0.
- **Latency**
  - Pin TCK edge to internal pulse: 3 `iClk`.
  - UpdDR `tck_rise` to `dm_access_valid`: 1 further `iClk`.
- **TCK rate limits**
  - Minimum TCK high/low time: 4 `iClk` periods.
  - Slower TCK is unconstrained.
- **Glitch filtering**
  - A TCK pulse shorter than 2 `iClk` may be missed.
  - No other filtering is applied.
- **Simultaneous events**
  - `dmihardreset` in the same cycle as a pending request cancels it; no strobe is issued.
- **Reset mid-scan**
  - `iRst_n` low during a scan aborts it immediately.
  - `dm_access_valid` deasserts asynchronously.

## Configuration
- **`DTM_IDCODE_EN` defined**
  - IR 0x01 selects the 32-bit IDCODE register (value `IDCODE`).
  - Reset and TLR select IDCODE.
- **`DTM_IDCODE_EN` undefined**
  - No IDCODE register exists; IR 0x01 selects BYPASS.
  - The reset IR value stays 0x01, so a DR scan after reset shifts out a single 0.

## Test plan
- **Reset/IDCODE**
  - Stimulus: reset, then five TMS=1 edges, then a 32-bit DR scan.
  - Required: `oTdo` shifts 0x1000_0001 LSB-first; `oTdoEn`=1 only during ShDR.
- **DTMCS read**
  - Stimulus: IR=0x10, then a 32-bit DR scan.
  - Required: captured value 0x0000_1071.
- **DMI write**
  - Stimulus: IR=0x11; scan addr=0x04, data=0xDEAD_BEEF, op=2.
  - Required: one cycle with `dm_access_valid`=1, `dm_write`=1, `dm_addr`=0x04, `dm_wdata`=0xDEAD_BEEF.
- **DMI read**
  - Stimulus: scan addr=0x11, op=1, with `dm_rdata`=0x0040_0C82; then a second scan with op=0.
  - Required: the second scan captures data=0x0040_0C82, op=0.
- **Sticky error**
  - Stimulus: scan op=3, then op=2.
  - Required: no strobe for either scan; DTMCS dmistat=2.
  - Stimulus: write DTMCS bit16=1.
  - Required: dmistat=0, and the next op=2 scan issues a strobe.
- **Reset mid-shift**
  - Stimulus: assert `iRst_n`=0 in ShDR of DMI.
  - Required: all outputs 0; TAP in TLR; no DMI strobe after release.

Source files
------------

// File: rtl/dmi_jtag_dtm_if.sv
// dmi_jtag_dtm_if: DMI request bus between the JTAG DTM (debugger) and the Debug Module (dm)
interface DBG_IF #(parameter int ABITS = 7);
  logic             dm_access_valid;
  logic             dm_read;
  logic             dm_write;
  logic [ABITS-1:0] dm_addr;
  logic [31:0]      dm_wdata;
  logic [31:0]      dm_rdata;
  modport debugger (output dm_access_valid, dm_read, dm_write, dm_addr, dm_wdata, input dm_rdata);
  modport dm       (input dm_access_valid, dm_read, dm_write, dm_addr, dm_wdata, output dm_rdata);
endinterface

// File: rtl/dmi_jtag_dtm.sv
// dmi_jtag_dtm: oversampled JTAG TAP with RISC-V DTM registers driving single-cycle DMI strobes; define DTM_IDCODE_EN to add the IDCODE register
module dmi_jtag_dtm #(
  parameter int          ABITS  = 7,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iTck,
  input  logic iTms,
  input  logic iTdi,
  output logic oTdo,
  output logic oTdoEn,
  DBG_IF.debugger dmi
);
  localparam int DW = ABITS + 34;
`ifdef DTM_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAUSE_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAUSE_IR, S_EX2_IR, S_UPD_IR
  } state_t;
  logic [2:0]       r_tck_s;
  logic [1:0]       r_tms_s, r_tdi_s;
  state_t           r_state, w_next;
  logic [4:0]       r_ir, r_ir_sh;
  logic [DW-1:0]    r_dr, w_cap, w_dr_sh;
  logic [1:0]       r_stat;
  logic             r_req, r_rd, r_wr;
  logic [ABITS-1:0] r_addr, r_last_addr;
  logic [31:0]      r_wdata, r_last_rdata;
  logic             w_tck_rise, w_tck_fall, w_tms, w_tdi;
  logic             w_sel_dmi, w_sel_dtmcs, w_sel_id, w_cap_dr, w_upd_dr;
  logic [1:0]       w_op;
  assign w_tck_rise  = r_tck_s[1] & ~r_tck_s[2];
  assign w_tck_fall  = ~r_tck_s[1] & r_tck_s[2];
  assign w_tms       = r_tms_s[1];
  assign w_tdi       = r_tdi_s[1];
  assign w_sel_dmi   = r_ir == 5'h11;
  assign w_sel_dtmcs = r_ir == 5'h10;
  assign w_sel_id    = ID_EN && r_ir == 5'h01;
  assign w_cap_dr    = w_tck_rise && r_state == S_CAP_DR;
  assign w_upd_dr    = w_tck_rise && r_state == S_UPD_DR;
  assign w_op        = r_dr[1:0];
  assign w_cap = w_sel_dmi   ? {r_last_addr, r_last_rdata, r_stat} :
                 w_sel_dtmcs ? {{(DW-15){1'b0}}, 3'd1, r_stat, 6'(ABITS), 4'd1} :
                 w_sel_id    ? {{(DW-32){1'b0}}, IDCODE[31:1], 1'b1} : '0;
  assign w_dr_sh = w_sel_dmi                ? {w_tdi, r_dr[DW-1:1]} :
                   (w_sel_dtmcs | w_sel_id) ? {{(DW-32){1'b0}}, w_tdi, r_dr[31:1]} :
                                              {{(DW-1){1'b0}}, w_tdi};
  assign oTdoEn              = r_state == S_SH_DR || r_state == S_SH_IR;
  assign dmi.dm_access_valid = r_req;
  assign dmi.dm_read         = r_req & r_rd;
  assign dmi.dm_write        = r_req & r_wr;
  assign dmi.dm_addr         = r_addr;
  assign dmi.dm_wdata        = r_wdata;
  // two-flop synchronisers, plus a third TCK flop for edge detection
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      r_tck_s <= '0;
      r_tms_s <= '0;
      r_tdi_s <= '0;
    end else begin
      r_tck_s <= {r_tck_s[1:0], iTck};
      r_tms_s <= {r_tms_s[0], iTms};
      r_tdi_s <= {r_tdi_s[0], iTdi};
    end
  // TAP state register
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) r_state <= S_TLR;
    else         r_state <= w_next;
  // IEEE 1149.1 next-state, evaluated only on a TCK rising edge
  always_comb begin
    w_next = r_state;
    if (w_tck_rise)
      case (r_state)
        S_TLR:      w_next = w_tms ? S_TLR      : S_RTI;
        S_RTI:      w_next = w_tms ? S_SEL_DR   : S_RTI;
        S_SEL_DR:   w_next = w_tms ? S_SEL_IR   : S_CAP_DR;
        S_CAP_DR:   w_next = w_tms ? S_EX1_DR   : S_SH_DR;
        S_SH_DR:    w_next = w_tms ? S_EX1_DR   : S_SH_DR;
        S_EX1_DR:   w_next = w_tms ? S_UPD_DR   : S_PAUSE_DR;
        S_PAUSE_DR: w_next = w_tms ? S_EX2_DR   : S_PAUSE_DR;
        S_EX2_DR:   w_next = w_tms ? S_UPD_DR   : S_SH_DR;
        S_UPD_DR:   w_next = w_tms ? S_SEL_DR   : S_RTI;
        S_SEL_IR:   w_next = w_tms ? S_TLR      : S_CAP_IR;
        S_CAP_IR:   w_next = w_tms ? S_EX1_IR   : S_SH_IR;
        S_SH_IR:    w_next = w_tms ? S_EX1_IR   : S_SH_IR;
        S_EX1_IR:   w_next = w_tms ? S_UPD_IR   : S_PAUSE_IR;
        S_PAUSE_IR: w_next = w_tms ? S_EX2_IR   : S_PAUSE_IR;
        S_EX2_IR:   w_next = w_tms ? S_UPD_IR   : S_SH_IR;
        default:    w_next = w_tms ? S_SEL_DR   : S_RTI;
      endcase
  end
  // instruction register: capture, shift LSB-first, update; TLR restores 0x01
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      r_ir    <= 5'h01;
      r_ir_sh <= 5'h01;
    end else if (w_tck_rise) begin
      if (r_state == S_TLR)    r_ir    <= 5'h01;
      if (r_state == S_CAP_IR) r_ir_sh <= 5'h01;
      if (r_state == S_SH_IR)  r_ir_sh <= {w_tdi, r_ir_sh[4:1]};
      if (r_state == S_UPD_IR) r_ir    <= r_ir_sh;
    end
  // data shift register sized by the selected DR, TDI entering at its MSB
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n)                                r_dr <= '0;
    else if (w_cap_dr)                          r_dr <= w_cap;
    else if (w_tck_rise && r_state == S_SH_DR)  r_dr <= w_dr_sh;
  // TDO presents the current LSB on the falling TCK edge
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) oTdo <= 1'b0;
    else if (w_tck_fall && r_state == S_SH_DR) oTdo <= r_dr[0];
    else if (w_tck_fall && r_state == S_SH_IR) oTdo <= r_ir_sh[0];
  // DMI request issue, sticky status and last-access tracking
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      r_stat       <= '0;
      r_req        <= 1'b0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_last_addr  <= '0;
      r_last_rdata <= '0;
    end else begin
      r_req <= 1'b0;
      if (r_req) begin
        r_last_addr <= r_addr;
        if (r_rd) r_last_rdata <= dmi.dm_rdata;
      end
      if (w_cap_dr && w_sel_dmi && r_req) r_stat <= 2'd3;
      if (w_upd_dr && w_sel_dtmcs && (r_dr[16] || r_dr[17])) r_stat <= 2'd0;
      if (w_upd_dr && w_sel_dmi && r_stat == 2'd0) begin
        if (w_op == 2'd3) r_stat <= 2'd2;
        else if (w_op != 2'd0) begin
          r_req   <= 1'b1;
          r_rd    <= w_op == 2'd1;
          r_wr    <= w_op == 2'd2;
          r_addr  <= r_dr[DW-1 -: ABITS];
          r_wdata <= r_dr[33:2];
        end
      end
    end
endmodule

// File: tb/tb_dmi_jtag_dtm.sv
// tb_dmi_jtag_dtm: drives JTAG scans and checks TDO data and DMI strobes against a transaction-level DTM model
module tb_dmi_jtag_dtm;
  localparam int AB = 7;
  localparam int DW = AB + 34;
  localparam int H  = 6;
  logic iClk = 1'b0, iRst_n = 1'b0, iTck = 1'b0, iTms = 1'b1, iTdi = 1'b0;
  logic oTdo, oTdoEn;
  DBG_IF #(.ABITS(AB)) dmi();
  dmi_jtag_dtm #(.ABITS(AB)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iTck(iTck), .iTms(iTms), .iTdi(iTdi),
    .oTdo(oTdo), .oTdoEn(oTdoEn), .dmi(dmi)
  );
  always #5 iClk = ~iClk;
  int errors = 0, checks = 0, en_err = 0, width_err = 0;
  logic [40:0] strobes[$];
  logic prev_v = 1'b0;
  logic [1:0]    m_stat  = '0;
  logic [AB-1:0] m_addr  = '0;
  logic [31:0]   m_rdata = '0;
  always @(negedge iClk) begin
    if (dmi.dm_access_valid) begin
      strobes.push_back({dmi.dm_read, dmi.dm_write, dmi.dm_addr, dmi.dm_wdata});
      if (prev_v) width_err++;
    end
    prev_v = dmi.dm_access_valid;
  end
  task automatic tck(input logic tms, input logic tdi, input logic exp_en, output logic tdo);
    iTms = tms;
    iTdi = tdi;
    tdo = oTdo;
    if (oTdoEn !== exp_en) en_err++;
    iTck = 1'b1;
    repeat (H) @(negedge iClk);
    iTck = 1'b0;
    repeat (H) @(negedge iClk);
  endtask
  task automatic scan_ir(input logic [4:0] v);
    logic t;
    logic [4:0] o;
    tck(1, 0, 0, t); tck(1, 0, 0, t); tck(0, 0, 0, t); tck(0, 0, 0, t);
    for (int i = 0; i < 5; i++) begin
      tck(i == 4, v[i], 1, t);
      o[i] = t;
    end
    tck(1, 0, 0, t); tck(0, 0, 0, t);
    checks++;
    if (o !== 5'b00001) begin errors++; $display("FAIL ir_capture got %b want 00001", o); end
  endtask
  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic t;
    dout = '0;
    tck(1, 0, 0, t); tck(0, 0, 0, t); tck(0, 0, 0, t);
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, din[i], 1, t);
      dout[i] = t;
    end
    tck(1, 0, 0, t); tck(0, 0, 0, t);
  endtask
  task automatic check_idle_dr(input string name);
    logic [63:0] din, dout, exp;
    din = {32'h0, 32'($urandom)};
`ifdef DTM_IDCODE_EN
    exp = 64'h1000_0001;
`else
    exp = {32'h0, din[30:0], 1'b0};
`endif
    scan_dr(32, din, dout);
    checks++;
    if (dout !== exp) begin errors++; $display("FAIL %s got %h want %h", name, dout, exp); end
  endtask
  task automatic dtmcs_scan(input logic [31:0] din);
    logic [63:0] dout, exp;
    exp = 64'h1071 | (64'(m_stat) << 10);
    scan_dr(32, {32'h0, din}, dout);
    checks++;
    if (dout !== exp) begin errors++; $display("FAIL dtmcs got %h want %h", dout, exp); end
    if (din[16] || din[17]) m_stat = 2'd0;
  endtask
  task automatic dmi_scan(input logic [AB-1:0] a, input logic [31:0] d, input logic [1:0] op, input logic [31:0] rd);
    logic [63:0] dout, exp;
    logic [40:0] es;
    int n_exp;
    dmi.dm_rdata = rd;
    strobes.delete();
    exp = {23'h0, m_addr, m_rdata, m_stat};
    scan_dr(DW, {23'h0, a, d, op}, dout);
    checks++;
    if (dout !== exp) begin errors++; $display("FAIL dmi_capture got %h want %h", dout, exp); end
    n_exp = 0;
    es = '0;
    if (m_stat == 2'd0) begin
      if (op == 2'd1) begin n_exp = 1; es = {2'b10, a, 32'h0}; m_addr = a; m_rdata = rd; end
      if (op == 2'd2) begin n_exp = 1; es = {2'b01, a, d}; m_addr = a; end
      if (op == 2'd3) m_stat = 2'd2;
    end
    checks++;
    if (strobes.size() != n_exp) begin
      errors++; $display("FAIL dmi_strobe_count got %0d want %0d", strobes.size(), n_exp);
    end else if (n_exp == 1) begin
      checks++;
      if (op == 2'd1 ? (strobes[0][40:32] !== es[40:32]) : (strobes[0] !== es)) begin
        errors++; $display("FAIL dmi_strobe got %h want %h", strobes[0], es);
      end
    end
  endtask
  task automatic test_reset();
    logic t;
    iRst_n = 1'b0;
    repeat (3) @(negedge iClk);
    checks++;
    if ({oTdo, oTdoEn, dmi.dm_access_valid, dmi.dm_read, dmi.dm_write} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {oTdo, oTdoEn, dmi.dm_access_valid, dmi.dm_read, dmi.dm_write});
    end
    checks++;
    if ({dmi.dm_addr, dmi.dm_wdata} !== '0) begin
      errors++; $display("FAIL reset_bus got %h want 0", {dmi.dm_addr, dmi.dm_wdata});
    end
    iRst_n = 1'b1;
    repeat (H) @(negedge iClk);
    for (int i = 0; i < 5; i++) tck(1, 0, 0, t);
    tck(0, 0, 0, t);
    check_idle_dr("reset_idcode");
    checks++;
    if (en_err !== 0) begin errors++; $display("FAIL tdo_en got %0d bad samples want 0", en_err); end
  endtask
  task automatic test_dtmcs();
    scan_ir(5'h10);
    dtmcs_scan(32'h0);
  endtask
  task automatic test_dmi_write();
    scan_ir(5'h11);
    dmi_scan(7'h04, 32'hDEAD_BEEF, 2'd2, $urandom);
  endtask
  task automatic test_dmi_read();
    dmi_scan(7'h11, $urandom, 2'd1, 32'h0040_0C82);
    dmi_scan(7'($urandom), $urandom, 2'd0, $urandom);
  endtask
  task automatic test_sticky();
    dmi_scan(7'h05, $urandom, 2'd3, $urandom);
    dmi_scan(7'h06, $urandom, 2'd2, $urandom);
    scan_ir(5'h10);
    dtmcs_scan(32'h0);
    dtmcs_scan(32'h1_0000);
    dtmcs_scan(32'h0);
    scan_ir(5'h11);
    dmi_scan(7'h07, $urandom, 2'd2, $urandom);
    dmi_scan(7'h08, $urandom, 2'd3, $urandom);
    scan_ir(5'h10);
    dtmcs_scan(32'h2_0000);
    dtmcs_scan(32'h0);
    scan_ir(5'h11);
    dmi_scan(7'h09, $urandom, 2'd1, $urandom);
  endtask
  task automatic test_random();
    logic [1:0] op;
    for (int k = 0; k < 14; k++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3 && ($urandom % 3) != 0) op = 2'd1;
      dmi_scan(7'($urandom), $urandom, op, $urandom);
      if (m_stat != 2'd0 && ($urandom % 2) == 0) begin
        scan_ir(5'h10);
        dtmcs_scan(($urandom % 2) ? 32'h1_0000 : 32'h2_0000);
        scan_ir(5'h11);
      end
    end
    checks++;
    if (width_err !== 0) begin errors++; $display("FAIL strobe_width got %0d long pulses want 0", width_err); end
  endtask
  task automatic test_reset_mid_shift();
    logic t;
    scan_ir(5'h11);
    tck(1, 0, 0, t); tck(0, 0, 0, t); tck(0, 0, 0, t);
    for (int i = 0; i < 10; i++) tck(0, 1'($urandom), 1, t);
    iRst_n = 1'b0;
    #1;
    checks++;
    if ({oTdo, oTdoEn, dmi.dm_access_valid, dmi.dm_read, dmi.dm_write} !== 5'b0) begin
      errors++; $display("FAIL midreset_outputs got %b want 00000", {oTdo, oTdoEn, dmi.dm_access_valid, dmi.dm_read, dmi.dm_write});
    end
    repeat (3) @(negedge iClk);
    iRst_n = 1'b1;
    m_stat = '0; m_addr = '0; m_rdata = '0;
    strobes.delete();
    repeat (H) @(negedge iClk);
    for (int i = 0; i < 6; i++) tck(1, 0, 0, t);
    checks++;
    if (strobes.size() != 0) begin errors++; $display("FAIL midreset_strobe got %0d want 0", strobes.size()); end
    tck(0, 0, 0, t);
    check_idle_dr("midreset_tlr");
    scan_ir(5'h11);
    dmi_scan(7'h00, 32'h0, 2'd0, $urandom);
  endtask
  initial begin
    dmi.dm_rdata = '0;
    test_reset();
    test_dtmcs();
    test_dmi_write();
    test_dmi_read();
    test_sticky();
    test_random();
    test_reset_mid_shift();
    checks++;
    if (en_err !== 0) begin errors++; $display("FAIL tdo_en_total got %0d bad samples want 0", en_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
